// File: rtl/ac97_sdata_in_deframer_pkg.sv
// Shared constants, slot geometry and FSM encoding for the AC97 sdata_in deframer.
package ac97_sdata_in_deframer_pkg;

  localparam int FRAME_BITS = 256;
  localparam int SLOT0_BITS = 16;
  localparam int SLOT_BITS  = 20;

  localparam logic [7:0] SLOT0_END    = 8'd15;
  localparam logic [7:0] SLOT1_END    = 8'd35;
  localparam logic [7:0] SLOT2_END    = 8'd55;
  localparam logic [7:0] SLOT3_END    = 8'd75;
  localparam logic [7:0] SLOT4_END    = 8'd95;
  localparam logic [7:0] SYNC_LOW_BIT = 8'd16;
  localparam logic [7:0] LAST_BIT     = 8'(FRAME_BITS - 1);

  localparam int TAG_READY = 15;
  localparam int TAG_SLOT1 = 14;
  localparam int TAG_SLOT2 = 13;
  localparam int TAG_SLOT3 = 12;
  localparam int TAG_SLOT4 = 11;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  // True on the last bit of any slot (slot0 ends at 15, then every 20 bits up to 255).
  function automatic logic is_slot_end(input logic [7:0] idx);
    return (idx >= SLOT0_END) && (((idx - SLOT0_END) % 8'(SLOT_BITS)) == 8'd0);
  endfunction

endpackage

// File: rtl/ac97_sdata_in_deframer_if.sv
// Serial input and decoded-field bundle between the AC97 link and the receive deframer.
interface ac97_sdata_in_deframer_if #(
  parameter int SAMPLE_WIDTH = 20
);
  logic                    sync;
  logic                    sdata_in;
  logic                    codec_ready;
  logic [11:0]             slot_valid;
  logic [6:0]              status_addr;
  logic [15:0]             status_data;
  logic                    status_valid;
  logic [SAMPLE_WIDTH-1:0] pcm_left;
  logic [SAMPLE_WIDTH-1:0] pcm_right;
  logic                    pcm_valid;
  logic                    frame_error;

  modport master (
    output sync, sdata_in,
    input  codec_ready, slot_valid, status_addr, status_data, status_valid,
           pcm_left, pcm_right, pcm_valid, frame_error
  );

  modport slave (
    input  sync, sdata_in,
    output codec_ready, slot_valid, status_addr, status_data, status_valid,
           pcm_left, pcm_right, pcm_valid, frame_error
  );
endinterface

// File: rtl/ac97_slot_shifter.sv
// MSB-first slot deserializer; word presents the slot including the bit sampled this cycle.
module ac97_slot_shifter
  import ac97_sdata_in_deframer_pkg::*;
(
  input  logic                 bit_clk,
  input  logic                 system_reset,
  input  logic                 load,
  input  logic                 shift_en,
  input  logic                 clear,
  input  logic                 din,
  output logic [SLOT_BITS-1:0] word
);

  // Only 19 history bits are needed: the 20th is the live input bit.
  logic [SLOT_BITS-2:0] shift_reg;

  always_ff @(posedge bit_clk) begin
    if (system_reset) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= {{(SLOT_BITS-2){1'b0}}, din};
    end else if (clear) begin
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[SLOT_BITS-3:0], din};
    end
  end

  assign word = {shift_reg, din};

endmodule

// File: rtl/ac97_sdata_in_deframer.sv
// AC97 receive deframer: aligns to sync, extracts tag/status/PCM slots, commits at bit 95.
// Optional sync checking with sticky frame_error when AC97_RX_SYNC_CHECK_EN is defined.
module ac97_sdata_in_deframer
  import ac97_sdata_in_deframer_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 20
) (
  input  logic                        bit_clk,
  input  logic                        system_reset,
  ac97_sdata_in_deframer_if.slave     rx
);

  rx_state_e state_reg, state_next;
  logic       sync_q_reg;
  logic [7:0] bit_cnt_reg;
  logic [7:0] bit_idx;
  logic       sync_rise;
  logic       sync_err;
  logic       recv_en;
  logic       commit;

  logic [SLOT_BITS-1:0] slot_word;
  logic                 unused_tag_low_bits;

  logic [15:3]             tag_pend_reg;
  logic [6:0]              addr_pend_reg;
  logic [15:0]             data_pend_reg;
  logic [SAMPLE_WIDTH-1:0] left_pend_reg;
  logic [SAMPLE_WIDTH-1:0] right_pend_reg;

  logic                    codec_ready_reg;
  logic [11:0]             slot_valid_reg;
  logic [6:0]              status_addr_reg;
  logic [15:0]             status_data_reg;
  logic                    status_valid_reg;
  logic [SAMPLE_WIDTH-1:0] pcm_left_reg;
  logic [SAMPLE_WIDTH-1:0] pcm_right_reg;
  logic                    pcm_valid_reg;

  assign sync_rise = rx.sync && !sync_q_reg;
  // Index of the bit being sampled on this edge.
  assign bit_idx   = sync_rise ? 8'd0 : bit_cnt_reg + 8'd1;

`ifdef AC97_RX_SYNC_CHECK_EN
  logic frame_error_reg;

  assign sync_err = (state_reg == RECV) &&
                    (sync_rise ? (bit_cnt_reg != LAST_BIT)
                               : ((bit_idx == SYNC_LOW_BIT && rx.sync) ||
                                  (bit_idx >= 8'd1 && bit_idx <= SLOT0_END && !rx.sync)));

  always_ff @(posedge bit_clk) begin
    if (system_reset) begin
      frame_error_reg <= 1'b0;
    end else if (sync_err) begin
      frame_error_reg <= 1'b1;
    end
  end

  assign rx.frame_error = frame_error_reg;
`else
  assign sync_err       = 1'b0;
  assign rx.frame_error = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    recv_en    = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      HUNT: begin
        if (sync_rise) begin
          state_next = RECV;
          recv_en    = 1'b1;
        end
      end
      RECV: begin
        if (sync_err) begin
          state_next = HUNT;
        end else begin
          recv_en = 1'b1;
          // A re-aligning sync rise drops the frame in progress.
          commit  = (bit_cnt_reg == SLOT4_END) && !sync_rise;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge bit_clk) begin
    if (system_reset) begin
      state_reg   <= HUNT;
      sync_q_reg  <= 1'b0;
      bit_cnt_reg <= 8'd0;
    end else begin
      state_reg  <= state_next;
      sync_q_reg <= rx.sync;
      if (recv_en) begin
        bit_cnt_reg <= bit_idx;
      end
    end
  end

  ac97_slot_shifter u_slot_shifter (
    .bit_clk      (bit_clk),
    .system_reset (system_reset),
    .load         (recv_en && sync_rise),
    .shift_en     (recv_en),
    .clear        (recv_en && is_slot_end(bit_idx)),
    .din          (rx.sdata_in),
    .word         (slot_word)
  );

  assign unused_tag_low_bits = ^slot_word[2:0];

  always_ff @(posedge bit_clk) begin
    if (system_reset) begin
      tag_pend_reg   <= '0;
      addr_pend_reg  <= '0;
      data_pend_reg  <= '0;
      left_pend_reg  <= '0;
      right_pend_reg <= '0;
    end else if (recv_en) begin
      case (bit_idx)
        SLOT0_END: tag_pend_reg   <= slot_word[15:3];
        SLOT1_END: addr_pend_reg  <= slot_word[18:12];
        SLOT2_END: data_pend_reg  <= slot_word[19:4];
        SLOT3_END: left_pend_reg  <= slot_word[SLOT_BITS-1 -: SAMPLE_WIDTH];
        SLOT4_END: right_pend_reg <= slot_word[SLOT_BITS-1 -: SAMPLE_WIDTH];
        default: ;
      endcase
    end
  end

  always_ff @(posedge bit_clk) begin
    if (system_reset) begin
      codec_ready_reg  <= 1'b0;
      slot_valid_reg   <= '0;
      status_addr_reg  <= '0;
      status_data_reg  <= '0;
      status_valid_reg <= 1'b0;
      pcm_left_reg     <= '0;
      pcm_right_reg    <= '0;
      pcm_valid_reg    <= 1'b0;
    end else begin
      status_valid_reg <= 1'b0;
      pcm_valid_reg    <= 1'b0;
      if (commit) begin
        codec_ready_reg <= tag_pend_reg[TAG_READY];
        slot_valid_reg  <= tag_pend_reg[TAG_SLOT1:3];
        if (tag_pend_reg[TAG_READY] && tag_pend_reg[TAG_SLOT1] && tag_pend_reg[TAG_SLOT2]) begin
          status_addr_reg  <= addr_pend_reg;
          status_data_reg  <= data_pend_reg;
          status_valid_reg <= 1'b1;
        end
        if (tag_pend_reg[TAG_READY] && tag_pend_reg[TAG_SLOT3] && tag_pend_reg[TAG_SLOT4]) begin
          pcm_left_reg  <= left_pend_reg;
          pcm_right_reg <= right_pend_reg;
          pcm_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign rx.codec_ready  = codec_ready_reg;
  assign rx.slot_valid   = slot_valid_reg;
  assign rx.status_addr  = status_addr_reg;
  assign rx.status_data  = status_data_reg;
  assign rx.status_valid = status_valid_reg;
  assign rx.pcm_left     = pcm_left_reg;
  assign rx.pcm_right    = pcm_right_reg;
  assign rx.pcm_valid    = pcm_valid_reg;

endmodule

// File: tb/tb_ac97_sdata_in_deframer.sv
// Self-checking bench: a codec model serializes whole frames; expectations come from slot-level rules.
module tb_ac97_sdata_in_deframer;

  logic bit_clk = 1'b0;
  logic system_reset;
  logic sync_drv;
  logic sdata_drv;

  int vectors     = 0;
  int miscompares = 0;

  logic        exp_ready;
  logic [11:0] exp_slotv;
  logic [6:0]  exp_addr;
  logic [15:0] exp_data;
  logic [19:0] exp_left;
  logic [19:0] exp_right;
  logic        exp_err;

  ac97_sdata_in_deframer_if #(.SAMPLE_WIDTH(20)) bus20 ();
  ac97_sdata_in_deframer_if #(.SAMPLE_WIDTH(16)) bus16 ();

  assign bus20.sync     = sync_drv;
  assign bus20.sdata_in = sdata_drv;
  assign bus16.sync     = sync_drv;
  assign bus16.sdata_in = sdata_drv;

  ac97_sdata_in_deframer #(.SAMPLE_WIDTH(20)) dut (
    .bit_clk      (bit_clk),
    .system_reset (system_reset),
    .rx           (bus20)
  );

  ac97_sdata_in_deframer #(.SAMPLE_WIDTH(16)) dut16 (
    .bit_clk      (bit_clk),
    .system_reset (system_reset),
    .rx           (bus16)
  );

  always #5 bit_clk = ~bit_clk;

  initial begin
    #5ms;
    $display("FAIL watchdog time limit expired got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    exp_ready = 1'b0;
    exp_slotv = '0;
    exp_addr  = '0;
    exp_data  = '0;
    exp_left  = '0;
    exp_right = '0;
    exp_err   = 1'b0;
  endtask

  task automatic reset_dut();
    system_reset = 1'b1;
    sync_drv     = 1'b0;
    sdata_drv    = 1'b0;
    repeat (3) @(negedge bit_clk);
    system_reset = 1'b0;
    clear_model();
  endtask

  task automatic check_values(input string name);
    vectors++;
    if ({bus20.codec_ready, bus20.slot_valid} !== {exp_ready, exp_slotv}) begin
      miscompares++;
      $display("FAIL %s tag_fields got %b/%h want %b/%h", name,
               bus20.codec_ready, bus20.slot_valid, exp_ready, exp_slotv);
    end
    vectors++;
    if ({bus20.status_addr, bus20.status_data} !== {exp_addr, exp_data}) begin
      miscompares++;
      $display("FAIL %s status got %h/%h want %h/%h", name,
               bus20.status_addr, bus20.status_data, exp_addr, exp_data);
    end
    vectors++;
    if ({bus20.pcm_left, bus20.pcm_right} !== {exp_left, exp_right}) begin
      miscompares++;
      $display("FAIL %s pcm20 got %h/%h want %h/%h", name,
               bus20.pcm_left, bus20.pcm_right, exp_left, exp_right);
    end
    vectors++;
    if ({bus16.pcm_left, bus16.pcm_right} !== {exp_left[19:4], exp_right[19:4]}) begin
      miscompares++;
      $display("FAIL %s pcm16 got %h/%h want %h/%h", name,
               bus16.pcm_left, bus16.pcm_right, exp_left[19:4], exp_right[19:4]);
    end
    vectors++;
    if (bus20.frame_error !== exp_err) begin
      miscompares++;
      $display("FAIL %s frame_error got %b want %b", name, bus20.frame_error, exp_err);
    end
  endtask

  // Sends nbits of one frame (sync high for bits 0..15); rst_at >= 0 pulses reset at that bit.
  task automatic send_frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                            input logic [19:0] s3, input logic [19:0] s4, input int nbits,
                            input int rst_at, input bit exp_commit, input string name);
    logic [255:0] bits;
    int st_cnt = 0;
    int pc_cnt = 0;
    int st_pos = -1;
    int pc_pos = -1;
    int p16_cnt = 0;
    bit committed;
    bit exp_st;
    bit exp_pc;
    bits = {tag, s1, s2, s3, s4, $urandom, $urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < nbits; k++) begin
      @(negedge bit_clk);
      if (bus20.status_valid === 1'b1) begin st_cnt++; st_pos = k; end
      if (bus20.pcm_valid === 1'b1)    begin pc_cnt++; pc_pos = k; end
      if (bus16.pcm_valid === 1'b1)    p16_cnt++;
      if (rst_at >= 0 && k == rst_at + 1) begin
        vectors++;
        if ({bus20.codec_ready, bus20.slot_valid, bus20.status_addr, bus20.status_data,
             bus20.status_valid, bus20.pcm_left, bus20.pcm_right, bus20.pcm_valid,
             bus20.frame_error} !== '0) begin
          miscompares++;
          $display("FAIL %s outputs_after_reset got nonzero (ready=%b slotv=%h pcm_l=%h) want all 0",
                   name, bus20.codec_ready, bus20.slot_valid, bus20.pcm_left);
        end
      end
      system_reset = (k == rst_at);
      sync_drv     = (k < 16);
      sdata_drv    = bits[255-k];
    end

    if (rst_at >= 0) clear_model();
    committed = exp_commit && (rst_at < 0) && (nbits > 97);
    exp_st = committed && tag[15] && tag[14] && tag[13];
    exp_pc = committed && tag[15] && tag[12] && tag[11];
    if (committed) begin
      exp_ready = tag[15];
      exp_slotv = tag[14:3];
      if (exp_st) begin
        exp_addr = s1[18:12];
        exp_data = s2[19:4];
      end
      if (exp_pc) begin
        exp_left  = s3;
        exp_right = s4;
      end
    end

    vectors++;
    if (st_cnt !== int'(exp_st) || (exp_st && st_pos !== 97)) begin
      miscompares++;
      $display("FAIL %s status_valid got %0d pulses at bit %0d want %0d at bit 97",
               name, st_cnt, st_pos, int'(exp_st));
    end
    vectors++;
    if (pc_cnt !== int'(exp_pc) || (exp_pc && pc_pos !== 97)) begin
      miscompares++;
      $display("FAIL %s pcm_valid got %0d pulses at bit %0d want %0d at bit 97",
               name, pc_cnt, pc_pos, int'(exp_pc));
    end
    vectors++;
    if (p16_cnt !== int'(exp_pc)) begin
      miscompares++;
      $display("FAIL %s pcm_valid16 got %0d pulses want %0d", name, p16_cnt, int'(exp_pc));
    end
    check_values(name);
    $display("frame %s tag=%h bits=%0d status_pulses=%0d pcm_pulses=%0d ready=%b",
             name, tag, nbits, st_cnt, pc_cnt, bus20.codec_ready);
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge bit_clk);
    vectors++;
    if ({bus20.status_valid, bus20.pcm_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_pulses got %b%b want 00", bus20.status_valid, bus20.pcm_valid);
    end
    check_values("reset");
    $display("reset checked");
  endtask

  task automatic test_directed();
    send_frame(16'hF800, 20'h26000, 20'h000F0, 20'hABCDE, 20'h12345, 256, -1, 1'b1, "all_valid");
    send_frame(16'h9800, 20'h15000, 20'h0ABC0, 20'h55555, 20'hAAAAA, 256, -1, 1'b1, "pcm_only");
    send_frame(16'h7800, 20'h7F000, 20'hFFFF0, 20'h0F0F0, 20'hF0F0F, 256, -1, 1'b1, "not_ready");
  endtask

  task automatic test_midstream();
    int pulses = 0;
    reset_dut();
    for (int k = 0; k < 150; k++) begin
      @(negedge bit_clk);
      if (bus20.status_valid === 1'b1 || bus20.pcm_valid === 1'b1) pulses++;
      sync_drv  = 1'b0;
      sdata_drv = 1'($urandom);
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL midstream_pulses got %0d want 0", pulses);
    end
    check_values("midstream");
    $display("midstream 150 bits without sync pulses=%0d", pulses);
    send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom),
               256, -1, 1'b1, "after_midstream");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      logic [15:0] tag;
      tag     = 16'($urandom);
      tag[15] = ($urandom_range(0, 3) != 0);
      send_frame(tag, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom),
                 256, -1, 1'b1, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_realign();
    bit realign_commits;
`ifdef AC97_RX_SYNC_CHECK_EN
    realign_commits = 1'b0;
`else
    realign_commits = 1'b1;
`endif
    send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom),
               120, -1, 1'b1, "short120");
    send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom),
               256, -1, realign_commits, "after_early_sync");
    send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom),
               256, -1, 1'b1, "recovered");
  endtask

  task automatic test_reset_mid();
    send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom),
               256, 60, 1'b1, "reset_at_60");
    send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom),
               256, -1, 1'b1, "after_reset");
  endtask

  initial begin
    system_reset = 1'b1;
    sync_drv     = 1'b0;
    sdata_drv    = 1'b0;
    clear_model();
    test_reset();
    test_directed();
    test_midstream();
    test_back_to_back();
    test_realign();
`ifdef AC97_RX_SYNC_CHECK_EN
    exp_err = 1'b1;
    check_values("sticky_error");
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
